multiplier_unsigned_pipelined: RTL

MULTIPLIER_UNSIGNED_PIPELINED -- requirements
Module: multiplier_unsigned_pipelined

---
 rtl/multiplier_unsigned_pipelined.sv | 73 +++++++
 1 files changed

// File: rtl/multiplier_unsigned_pipelined.sv
// Pipelined 32x32 -> 64-bit unsigned shift-add multiplier.
// Each of STAGES register stages runs 32/STAGES shift-add iterations on its own P/M pair.
module multiplier_unsigned_pipelined #(
    parameter int STAGES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        i_valid,
    input  logic [31:0] i_multiplicand,
    input  logic [31:0] i_multiplier,
    output logic        o_valid,
    output logic [31:0] o_product_hi,
    output logic [31:0] o_product_lo
);

    localparam int ITER = 32 / STAGES;

    // One stage worth of shift-add steps; the carry out of the upper-half add
    // becomes the new MSB as P shifts right.
    function automatic logic [63:0] shift_add(input logic [63:0] p, input logic [31:0] m);
        logic [63:0] acc;
        logic [32:0] sum;
        acc = p;
        for (int k = 0; k < ITER; k++) begin
            if (acc[0])
                sum = {1'b0, acc[63:32]} + {1'b0, m};
            else
                sum = {1'b0, acc[63:32]};
            acc = {sum, acc[31:1]};
        end
        return acc;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : gen_stage
            logic [63:0] p_reg;
            logic [31:0] m_reg;
            logic        valid_reg;
            logic [63:0] p_in;
            logic [31:0] m_in;
            logic        valid_in;

            if (gi == 0) begin : g_first
                assign p_in     = {32'b0, i_multiplier};
                assign m_in     = i_multiplicand;
                assign valid_in = i_valid;
            end else begin : g_next
                assign p_in     = gen_stage[gi-1].p_reg;
                assign m_in     = gen_stage[gi-1].m_reg;
                assign valid_in = gen_stage[gi-1].valid_reg;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    p_reg     <= '0;
                    m_reg     <= '0;
                    valid_reg <= 1'b0;
                end else if (!stall) begin
                    p_reg     <= shift_add(p_in, m_in);
                    m_reg     <= m_in;
                    valid_reg <= valid_in;
                end
            end
        end
    endgenerate

    assign o_valid      = gen_stage[STAGES-1].valid_reg;
    assign o_product_hi = gen_stage[STAGES-1].p_reg[63:32];
    assign o_product_lo = gen_stage[STAGES-1].p_reg[31:0];

endmodule
